// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read, one-write register file with byte-lane writes,
// registered reads with valid flags and write-to-read bypass.
module reg_file_2r1w #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_DEPTH = 16,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int ZERO_REG0      = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]  i_write_addr,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_write_be,
    input  logic                      i_rd_en_a,
    input  logic [ADDRESS_WIDTH-1:0]  i_rd_addr_a,
    output logic [DATA_WIDTH-1:0]     o_rd_data_a,
    output logic                      o_rd_valid_a,
    input  logic                      i_rd_en_b,
    input  logic [ADDRESS_WIDTH-1:0]  i_rd_addr_b,
    output logic [DATA_WIDTH-1:0]     o_rd_data_b,
    output logic                      o_rd_valid_b
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [REGISTER_DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [REGISTER_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
    logic                  wr_ok, rd_ok_a, rd_ok_b;

    // Address maps to a real, writable register (out-of-range and hardwired zero excluded)
    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        return (32'(a) < REGISTER_DEPTH) && !(ZERO_REG0 != 0 && a == '0);
    endfunction

    // Reads index the post-write array so same-cycle writes bypass to the read ports
    always_comb begin
        wr_ok = i_write_enable && addr_ok(i_write_addr);
        rd_ok_a = addr_ok(i_rd_addr_a);
        rd_ok_b = addr_ok(i_rd_addr_b);
        regs_d = regs_q;
        for (int k = 0; k < LANES; k++)
            if (wr_ok && i_write_be[k]) regs_d[i_write_addr][8*k +: 8] = i_write_data[8*k +: 8];
        rd_data_a_d = !i_rd_en_a ? rd_data_a_q : rd_ok_a ? regs_d[i_rd_addr_a] : '0;
        rd_data_b_d = !i_rd_en_b ? rd_data_b_q : rd_ok_b ? regs_d[i_rd_addr_b] : '0;
        rd_valid_a_d = i_rd_en_a;
        rd_valid_b_d = i_rd_en_b;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs_q       <= '{default: '0};
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    assign o_rd_data_a  = rd_data_a_q;
    assign o_rd_data_b  = rd_data_b_q;
    assign o_rd_valid_a = rd_valid_a_q;
    assign o_rd_valid_b = rd_valid_b_q;
endmodule
